// File: rtl/noc_pkg.sv
// Shared NoC types: flit-type encoding, allocator FSM states and the
// helpers that classify a flit by its two-bit type field.
package noc_pkg;

  localparam int FLIT_WIDTH_DEF = 34;
  localparam int NUM_IN         = 2;

  typedef enum logic [1:0] {
    FT_HEAD      = 2'b00,
    FT_BODY      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

  // Callers pass the top two bits of a flit.
  function automatic flit_type_e flit_type(input logic [1:0] hdr);
    return flit_type_e'(hdr);
  endfunction

  function automatic logic is_head(input flit_type_e t);
    return (t == FT_HEAD) || (t == FT_HEAD_TAIL);
  endfunction

  function automatic logic is_last(input flit_type_e t);
    return (t == FT_TAIL) || (t == FT_HEAD_TAIL);
  endfunction

endpackage

// File: rtl/flit_pipe_reg.sv
// Single-entry valid/ready register driving the output link. The entry can
// be refilled in the same cycle that the downstream stage drains it.
module flit_pipe_reg #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             can_load_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign can_load_o = ~valid_q | ready_i;
  assign valid_o    = valid_q;
  assign data_o     = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/output_port_alloc.sv
// One router output port: requests the arbiter for packet heads, holds the
// grant from head to tail, and forwards the owning input through a register.
module output_port_alloc
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = FLIT_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [NUM_IN-1:0]            in_valid_i,
  input  logic [NUM_IN*FLIT_WIDTH-1:0] in_flit_i,
  output logic [NUM_IN-1:0]            in_ready_o,
  output logic [NUM_IN-1:0]            arb_req_o,
  input  logic [NUM_IN-1:0]            arb_grant_i,
  output logic                         arb_update_o,
  output logic                         out_valid_o,
  output logic [FLIT_WIDTH-1:0]        out_flit_o,
  input  logic                         out_ready_i,
  output logic                         proto_err_o
);

  alloc_state_e state_q, state_d;
  logic         lock_q, lock_d;
  logic         hd_seen_q, hd_seen_d;
  logic         err_q, err_d;

  logic [NUM_IN-1:0][FLIT_WIDTH-1:0] in_vec;
  flit_type_e [NUM_IN-1:0]           in_type;
  logic [NUM_IN-1:0]                 in_is_hd;
  logic [NUM_IN-1:0]                 eff_gnt;
  logic [FLIT_WIDTH-1:0]             sel_flit;
  flit_type_e                        sel_type;
  logic                              can_load;
  logic                              accept;

  assign in_vec = in_flit_i;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_in
    assign in_type[k]  = flit_type(in_vec[k][FLIT_WIDTH-1 -: 2]);
    assign in_is_hd[k] = is_head(in_type[k]);
  end

  assign sel_flit = in_vec[lock_q];
  assign sel_type = flit_type(sel_flit[FLIT_WIDTH-1 -: 2]);

  // All handshake outputs are forced low while reset is held, even if the
  // state register still shows a packet in flight.
  always_comb begin
    state_d      = state_q;
    lock_d       = lock_q;
    hd_seen_d    = hd_seen_q;
    err_d        = err_q;
    arb_req_o    = '0;
    in_ready_o   = '0;
    arb_update_o = 1'b0;
    accept       = 1'b0;
    eff_gnt      = '0;
    if (!arst) begin
      unique case (state_q)
        ST_IDLE: begin
          arb_req_o = in_valid_i & in_is_hd;
          eff_gnt   = arb_grant_i & arb_req_o;
          if ((in_valid_i & ~in_is_hd) != '0)
            err_d = 1'b1;
          if ((arb_grant_i == 2'b11) || ((arb_grant_i & ~arb_req_o) != '0))
            err_d = 1'b1;
          // A double grant resolves to input 0.
          if (eff_gnt != '0) begin
            state_d   = ST_LOCKED;
            lock_d    = ~eff_gnt[0];
            hd_seen_d = 1'b0;
          end
        end
        ST_LOCKED: begin
          in_ready_o[lock_q] = can_load;
          accept             = in_valid_i[lock_q] & can_load;
          if (accept) begin
            hd_seen_d = 1'b1;
            if (hd_seen_q && (sel_type == FT_HEAD))
              err_d = 1'b1;
            if (is_last(sel_type)) begin
              arb_update_o = 1'b1;
              state_d      = ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      lock_q    <= 1'b0;
      hd_seen_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      hd_seen_q <= hd_seen_d;
      err_q     <= err_d;
    end
  end

  assign proto_err_o = err_q;

  flit_pipe_reg #(
    .WIDTH(FLIT_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .arst      (arst),
    .load_i    (accept),
    .data_i    (sel_flit),
    .ready_i   (out_ready_i),
    .can_load_o(can_load),
    .valid_o   (out_valid_o),
    .data_o    (out_flit_o)
  );

endmodule

// File: tb/tb_output_port_alloc.sv
// Bench for output_port_alloc: queue-fed input sources, a round-robin
// arbiter stand-in, and a packet-level model of the expected output order.
module tb_output_port_alloc;
  import noc_pkg::*;

  localparam int W = 34;

  logic           clk = 1'b0;
  logic           arst;
  logic [1:0]     in_valid;
  logic [2*W-1:0] in_flit;
  logic [1:0]     in_ready_o, arb_req_o, arb_grant;
  logic           arb_update_o, out_valid_o, out_ready, proto_err_o;
  logic [W-1:0]   out_flit_o;

  always #5 clk = ~clk;

  output_port_alloc #(.FLIT_WIDTH(W)) dut (
    .clk(clk), .arst(arst), .in_valid_i(in_valid), .in_flit_i(in_flit),
    .in_ready_o(in_ready_o), .arb_req_o(arb_req_o), .arb_grant_i(arb_grant),
    .arb_update_o(arb_update_o), .out_valid_o(out_valid_o), .out_flit_o(out_flit_o),
    .out_ready_i(out_ready), .proto_err_o(proto_err_o)
  );

  // Round-robin arbiter stand-in: favoured input rotates past the last winner on update.
  logic       prio_q, last_q, force_en;
  logic [1:0] gnt_rr, gnt_force;
  always_comb begin
    gnt_rr = 2'b00;
    if (arb_req_o[prio_q])       gnt_rr[prio_q]  = 1'b1;
    else if (arb_req_o[~prio_q]) gnt_rr[~prio_q] = 1'b1;
  end
  assign arb_grant = force_en ? gnt_force : gnt_rr;
  always @(posedge clk) begin
    if (arst) begin
      prio_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      if (gnt_rr != 2'b00) last_q <= gnt_rr[1];
      if (arb_update_o)    prio_q <= ~last_q;
    end
  end

  int nchecks = 0, nfail = 0;
  int cyc, rdy_mode, lo_s, lo_e;
  logic [W-1:0] q0[$], q1[$], ref0[$], ref1[$], obs_q[$], exp_q[$];
  int           len0[$], len1[$];
  logic         lg_outv[$], lg_upd[$], lg_err[$];
  logic [1:0]   lg_req[$], lg_rdy[$];
  logic [W-1:0] lg_flit[$];

  function automatic logic [W-1:0] mkflit(logic [1:0] t, int src, int pk, int idx);
    logic [W-1:0] f;
    f[W-1 -: 2] = t;
    f[W-3:0]    = {src[0], pk[7:0], idx[3:0], 19'($urandom)};
    return f;
  endfunction

  task automatic push_pkt(int src, int pk, int len);
    logic [W-1:0] f;
    logic [1:0]   t;
    for (int i = 0; i < len; i++) begin
      if (len == 1)         t = FT_HEAD_TAIL;
      else if (i == 0)      t = FT_HEAD;
      else if (i == len-1)  t = FT_TAIL;
      else                  t = FT_BODY;
      f = mkflit(t, src, pk, i);
      if (src == 0) begin q0.push_back(f); ref0.push_back(f); end
      else          begin q1.push_back(f); ref1.push_back(f); end
    end
    if (src == 0) len0.push_back(len); else len1.push_back(len);
  endtask

  task automatic drive();
    in_valid[0]      = (q0.size() > 0);
    in_valid[1]      = (q1.size() > 0);
    in_flit[W-1:0]   = (q0.size() > 0) ? q0[0] : '0;
    in_flit[2*W-1:W] = (q1.size() > 0) ? q1[0] : '0;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 9) < 7);
      default: out_ready = !(cyc >= lo_s && cyc <= lo_e);
    endcase
  endtask

  task automatic clear_logs();
    lg_outv.delete(); lg_upd.delete(); lg_err.delete(); lg_req.delete();
    lg_rdy.delete(); lg_flit.delete(); obs_q.delete(); cyc = 0;
  endtask

  // One clock: sample at negedge, then retire accepted flits and re-drive.
  task automatic step();
    logic [1:0] acc;
    @(negedge clk);
    lg_outv.push_back(out_valid_o); lg_upd.push_back(arb_update_o);
    lg_err.push_back(proto_err_o);  lg_req.push_back(arb_req_o);
    lg_rdy.push_back(in_ready_o);   lg_flit.push_back(out_flit_o);
    acc = in_valid & in_ready_o;
    if (out_valid_o && out_ready) obs_q.push_back(out_flit_o);
    @(posedge clk); #1;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    cyc++;
    drive();
  endtask

  task automatic run_until(int n, int budget, output bit ok);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin step(); c++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic do_reset();
    arst = 1'b1; force_en = 1'b0;
    q0.delete(); q1.delete(); ref0.delete(); ref1.delete(); len0.delete(); len1.delete();
    drive();
    @(posedge clk); #1;
    arst = 1'b0;
    clear_logs();
    drive();
  endtask

  // Packet-level model: each arbitration picks the favoured input if it has
  // a packet pending, whole packets are emitted, then priority passes on.
  task automatic build_exp();
    int p0 = 0, p1 = 0, i0 = 0, i1 = 0, pr = 0, w;
    exp_q.delete();
    while (p0 < len0.size() || p1 < len1.size()) begin
      if (pr == 0) w = (p0 < len0.size()) ? 0 : 1;
      else         w = (p1 < len1.size()) ? 1 : 0;
      if (w == 0) begin
        for (int j = 0; j < len0[p0]; j++) begin exp_q.push_back(ref0[i0]); i0++; end
        p0++;
      end else begin
        for (int j = 0; j < len1[p1]; j++) begin exp_q.push_back(ref1[i1]); i1++; end
        p1++;
      end
      pr = 1 - w;
    end
  endtask

  task automatic test_reset();
    arst = 1'b1; rdy_mode = 0;
    q0.push_back(mkflit(FT_HEAD, 0, 0, 0)); q1.push_back(mkflit(FT_HEAD, 1, 0, 0));
    drive();
    @(posedge clk); #1;
    @(negedge clk);
    nchecks++; if (arb_req_o !== 2'b00) begin nfail++; $display("FAIL reset_req got=%b exp=00", arb_req_o); end
    nchecks++; if (in_ready_o !== 2'b00) begin nfail++; $display("FAIL reset_ready got=%b exp=00", in_ready_o); end
    nchecks++; if (arb_update_o !== 1'b0) begin nfail++; $display("FAIL reset_update got=%b exp=0", arb_update_o); end
    nchecks++; if (out_valid_o !== 1'b0) begin nfail++; $display("FAIL reset_outv got=%b exp=0", out_valid_o); end
    nchecks++; if (out_flit_o !== '0) begin nfail++; $display("FAIL reset_flit got=%h exp=0", out_flit_o); end
    nchecks++; if (proto_err_o !== 1'b0) begin nfail++; $display("FAIL reset_err got=%b exp=0", proto_err_o); end
    @(posedge clk); #1;
    arst = 1'b0; q0.delete(); q1.delete(); clear_logs(); drive();
  endtask

  task automatic test_single_packet();
    do_reset(); rdy_mode = 0;
    push_pkt(0, 1, 3); drive();
    for (int i = 0; i < 6; i++) step();
    nchecks++; if (lg_req[0] !== 2'b01) begin nfail++; $display("FAIL single_req got=%b exp=01", lg_req[0]); end
    nchecks++; if (lg_rdy[1] !== 2'b01) begin nfail++; $display("FAIL single_ready got=%b exp=01", lg_rdy[1]); end
    nchecks++; if (lg_outv[1] !== 1'b0) begin nfail++; $display("FAIL single_outv1 got=%b exp=0", lg_outv[1]); end
    for (int c = 2; c <= 4; c++) begin
      nchecks++;
      if (lg_outv[c] !== 1'b1 || lg_flit[c] !== ref0[c-2]) begin
        nfail++; $display("FAIL single_flit c%0d got=%b/%h exp=1/%h", c, lg_outv[c], lg_flit[c], ref0[c-2]);
      end
    end
    nchecks++; if (lg_outv[5] !== 1'b0) begin nfail++; $display("FAIL single_outv5 got=%b exp=0", lg_outv[5]); end
    for (int c = 0; c < 6; c++) begin
      nchecks++;
      if (lg_upd[c] !== (c == 3)) begin nfail++; $display("FAIL single_upd c%0d got=%b exp=%b", c, lg_upd[c], (c == 3)); end
    end
  endtask

  task automatic test_contention();
    bit ok;
    logic [6:0] pat;
    do_reset(); rdy_mode = 0;
    push_pkt(0, 2, 3); push_pkt(1, 3, 3); drive();
    run_until(6, 40, ok);
    step();
    nchecks++; if (!ok) begin nfail++; $display("FAIL cont_timeout got=%0d flits exp=6", obs_q.size()); end
    build_exp();
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      nchecks++; if (obs_q[i] !== exp_q[i]) begin nfail++; $display("FAIL cont_order i%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    for (int c = 2; c <= 8; c++) pat[c-2] = lg_outv[c];
    nchecks++; if (pat !== 7'b1110111) begin nfail++; $display("FAIL cont_bubble got=%b exp=1110111", pat); end
  endtask

  task automatic test_head_tail();
    do_reset(); rdy_mode = 0;
    push_pkt(1, 4, 1); push_pkt(1, 5, 1); drive();
    for (int i = 0; i < 5; i++) step();
    nchecks++; if (lg_req[0] !== 2'b10) begin nfail++; $display("FAIL ht_req got=%b exp=10", lg_req[0]); end
    nchecks++; if (lg_rdy[1] !== 2'b10) begin nfail++; $display("FAIL ht_ready got=%b exp=10", lg_rdy[1]); end
    nchecks++; if (lg_upd[0] !== 1'b0 || lg_upd[1] !== 1'b1) begin nfail++; $display("FAIL ht_upd got=%b%b exp=01", lg_upd[0], lg_upd[1]); end
    nchecks++; if (lg_req[2] !== 2'b10 || lg_rdy[2] !== 2'b00) begin nfail++; $display("FAIL ht_idle got=%b/%b exp=10/00", lg_req[2], lg_rdy[2]); end
    nchecks++; if (lg_outv[2] !== 1'b1 || lg_flit[2] !== ref1[0]) begin nfail++; $display("FAIL ht_flit got=%b/%h exp=1/%h", lg_outv[2], lg_flit[2], ref1[0]); end
    nchecks++; if (lg_upd[3] !== 1'b1) begin nfail++; $display("FAIL ht_upd2 got=%b exp=1", lg_upd[3]); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset(); rdy_mode = 2; lo_s = 3; lo_e = 7;
    push_pkt(0, 6, 6); drive();
    run_until(6, 40, ok);
    nchecks++; if (!ok) begin nfail++; $display("FAIL bp_timeout got=%0d flits exp=6", obs_q.size()); end
    for (int c = 3; c <= 7; c++) begin
      nchecks++;
      if (lg_outv[c] !== 1'b1 || lg_flit[c] !== ref0[1] || lg_rdy[c] !== 2'b00) begin
        nfail++; $display("FAIL bp_hold c%0d got=%b/%h/%b exp=1/%h/00", c, lg_outv[c], lg_flit[c], lg_rdy[c], ref0[1]);
      end
    end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      nchecks++; if (obs_q[i] !== ref0[i]) begin nfail++; $display("FAIL bp_order i%0d got=%h exp=%h", i, obs_q[i], ref0[i]); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_err_body();
    do_reset(); rdy_mode = 0;
    q0.push_back(mkflit(FT_BODY, 0, 11, 1)); drive();
    for (int i = 0; i < 4; i++) step();
    for (int c = 0; c < 4; c++) begin
      nchecks++; if (lg_req[c] !== 2'b00 || lg_rdy[c] !== 2'b00) begin nfail++; $display("FAIL body_req c%0d got=%b/%b exp=00/00", c, lg_req[c], lg_rdy[c]); end
    end
    nchecks++; if (q0.size() !== 1) begin nfail++; $display("FAIL body_consumed got=%0d exp=1", q0.size()); end
    nchecks++; if (lg_err[0] !== 1'b0 || lg_err[1] !== 1'b1 || lg_err[3] !== 1'b1) begin
      nfail++; $display("FAIL body_err got=%b%b%b exp=011", lg_err[0], lg_err[1], lg_err[3]);
    end
    q0.delete(); drive();
    for (int i = 0; i < 3; i++) step();
    nchecks++; if (proto_err_o !== 1'b1) begin nfail++; $display("FAIL body_sticky got=%b exp=1", proto_err_o); end
    do_reset();
    nchecks++; if (proto_err_o !== 1'b0) begin nfail++; $display("FAIL body_clear got=%b exp=0", proto_err_o); end
  endtask

  task automatic test_grant11();
    bit ok;
    do_reset(); rdy_mode = 0;
    push_pkt(0, 7, 2); push_pkt(1, 8, 2);
    force_en = 1'b1; gnt_force = 2'b11; drive();
    step();
    force_en = 1'b0;
    run_until(4, 40, ok);
    nchecks++; if (!ok) begin nfail++; $display("FAIL g11_timeout got=%0d flits exp=4", obs_q.size()); end
    nchecks++; if (lg_rdy[1] !== 2'b01) begin nfail++; $display("FAIL g11_lock got=%b exp=01", lg_rdy[1]); end
    nchecks++; if (proto_err_o !== 1'b1) begin nfail++; $display("FAIL g11_err got=%b exp=1", proto_err_o); end
    build_exp();
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      nchecks++; if (obs_q[i] !== exp_q[i]) begin nfail++; $display("FAIL g11_order i%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int nupd;
    do_reset(); rdy_mode = 0;
    push_pkt(0, 9, 4); drive();
    step(); step();
    arst = 1'b1; q0.delete(); ref0.delete(); len0.delete(); drive();
    step();
    arst = 1'b0; obs_q.delete();
    push_pkt(1, 10, 2); drive();
    run_until(2, 30, ok);
    nchecks++; if (lg_rdy[1] !== 2'b01) begin nfail++; $display("FAIL rmid_hdacc got=%b exp=01", lg_rdy[1]); end
    nchecks++; if ((lg_upd[0] | lg_upd[1] | lg_upd[2]) !== 1'b0) begin nfail++; $display("FAIL rmid_upd got=%b%b%b exp=000", lg_upd[0], lg_upd[1], lg_upd[2]); end
    nchecks++; if (lg_outv[3] !== 1'b0 || lg_req[3] !== 2'b10) begin nfail++; $display("FAIL rmid_idle got=%b/%b exp=0/10", lg_outv[3], lg_req[3]); end
    nchecks++; if (!ok) begin nfail++; $display("FAIL rmid_timeout got=%0d flits exp=2", obs_q.size()); end
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      nchecks++; if (obs_q[i] !== ref1[i]) begin nfail++; $display("FAIL rmid_order i%0d got=%h exp=%h", i, obs_q[i], ref1[i]); end
    end
    nupd = 0;
    foreach (lg_upd[c]) if (lg_upd[c] === 1'b1) nupd++;
    nchecks++; if (nupd !== 1) begin nfail++; $display("FAIL rmid_npulse got=%0d exp=1", nupd); end
  endtask

  task automatic test_random();
    bit ok;
    int n0, n1, nupd, pk;
    for (int it = 0; it < 6; it++) begin
      do_reset(); rdy_mode = 1;
      n0 = $urandom_range(1, 3); n1 = $urandom_range(1, 3); pk = 20 + it * 8;
      for (int p = 0; p < n0; p++) push_pkt(0, pk + p, $urandom_range(1, 5));
      for (int p = 0; p < n1; p++) push_pkt(1, pk + 4 + p, $urandom_range(1, 5));
      drive();
      build_exp();
      run_until(exp_q.size(), 400, ok);
      step(); step();
      nchecks++; if (!ok || obs_q.size() !== exp_q.size()) begin nfail++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        nchecks++; if (obs_q[i] !== exp_q[i]) begin nfail++; $display("FAIL rnd%0d_order i%0d got=%h exp=%h", it, i, obs_q[i], exp_q[i]); end
      end
      nupd = 0;
      foreach (lg_upd[c]) if (lg_upd[c] === 1'b1) nupd++;
      nchecks++; if (nupd !== n0 + n1) begin nfail++; $display("FAIL rnd%0d_npulse got=%0d exp=%0d", it, nupd, n0 + n1); end
      nchecks++; if (proto_err_o !== 1'b0) begin nfail++; $display("FAIL rnd%0d_err got=%b exp=0", it, proto_err_o); end
    end
    rdy_mode = 0;
  endtask

  initial begin
    arst = 1'b1; in_valid = '0; in_flit = '0; out_ready = 1'b1;
    force_en = 1'b0; gnt_force = '0; rdy_mode = 0; lo_s = 0; lo_e = -1; cyc = 0;
    test_reset();
    test_single_packet();
    test_contention();
    test_head_tail();
    test_backpressure();
    test_err_body();
    test_grant11();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
